// File: rtl/slave_port_arbiter.sv
// Per-slave-port AHB arbiter: one-hot address-phase grant and a registered data-phase owner.
// Define BM_ARB_ROUND_ROBIN_EN for round-robin priority; otherwise fixed priority (lowest index wins).
module slave_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] hold,
  input  logic               hready,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    hmaster,
  output logic [ID_W-1:0]    hmaster_data,
  output logic               data_valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t          state;
  logic [ID_W-1:0] win;

  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [ID_W-1:0] idx);
    logic [NUM_REQ-1:0] o;
    o      = '0;
    o[idx] = 1'b1;
    return o;
  endfunction

`ifdef BM_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr;

  // Lowest requester above the last winner; if none, wrap to the lowest requester overall.
  function automatic logic [ID_W-1:0] pick(input logic [NUM_REQ-1:0] r,
                                           input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] w_any;
    logic [ID_W-1:0] w_hi;
    logic            hi_found;
    w_any    = '0;
    w_hi     = '0;
    hi_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (r[i]) begin
        w_any = ID_W'(i);
        if (i > int'(ptr)) begin
          w_hi     = ID_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    return hi_found ? w_hi : w_any;
  endfunction

  always_comb win = pick(req, rr_ptr);
`else
  function automatic logic [ID_W-1:0] pick(input logic [NUM_REQ-1:0] r);
    logic [ID_W-1:0] w;
    w = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (r[i]) w = ID_W'(i);
    end
    return w;
  endfunction

  always_comb win = pick(req);
`endif

  // Everything advances only on hready; a stalled slave freezes both phases.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state        <= IDLE;
      gnt          <= '0;
      hmaster      <= '0;
      hmaster_data <= '0;
      data_valid   <= 1'b0;
`ifdef BM_ARB_ROUND_ROBIN_EN
      rr_ptr       <= ID_W'(NUM_REQ - 1);
`endif
    end else if (hready) begin
      hmaster_data <= hmaster;
      data_valid   <= |gnt;
      case (state)
        IDLE: begin
          if (|req) begin
            state   <= OWNED;
            gnt     <= to_onehot(win);
            hmaster <= win;
`ifdef BM_ARB_ROUND_ROBIN_EN
            rr_ptr  <= win;
`endif
          end
        end
        OWNED: begin
          if (hold[hmaster]) begin
            state <= OWNED;
          end else if (|req) begin
            state   <= OWNED;
            gnt     <= to_onehot(win);
            hmaster <= win;
`ifdef BM_ARB_ROUND_ROBIN_EN
            rr_ptr  <= win;
`endif
          end else begin
            state   <= IDLE;
            gnt     <= '0;
            hmaster <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          gnt     <= '0;
          hmaster <= '0;
        end
      endcase
    end
  end

endmodule
